// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with reloadable pattern and saturating count.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask (pattern_mask).
module seq_pattern_detector #(
  parameter int                     PATTERN_LEN  = 6,
  parameter logic [PATTERN_LEN-1:0] PATTERN_INIT = 6'b010111,
  parameter int                     COUNT_W      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   value_valid,
  input  logic                   value,
  input  logic                   overlap_en,
  input  logic                   pattern_load,
  input  logic [PATTERN_LEN-1:0] pattern_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PATTERN_LEN-1:0] pattern_mask,
`endif
  input  logic                   count_clr,
  output logic                   match,
  output logic                   armed,
  output logic [COUNT_W-1:0]     match_count
);

  localparam int FW = $clog2(PATTERN_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);
  localparam logic [FW-1:0] LAST = FW'(PATTERN_LEN - 1);

  typedef enum logic {
    FILL,
    ARMED
  } state_t;

  state_t                 state_q, state_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [PATTERN_LEN-2:0] hist_q, hist_d;
  logic [PATTERN_LEN-1:0] pat_q;
  logic [PATTERN_LEN-1:0] mask_q;
  logic [PATTERN_LEN-1:0] window;
  logic                   take;
  logic                   hit;

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_q <= '1;
    end else if (pattern_load) begin
      mask_q <= pattern_mask;
    end
  end
`else
  assign mask_q = '1;
`endif

  always_comb begin
    window  = {hist_q, value};
    take    = value_valid && !pattern_load;
    hit     = 1'b0;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    if (take) begin
      hist_d = window[PATTERN_LEN-2:0];
      // a window is complete on the sample that fills it or any later one
      if (state_q == ARMED || fill_q == LAST) begin
        hit = (((window ^ pat_q) & mask_q) == '0);
      end
    end
    if (pattern_load) begin
      fill_d = '0;
    end else if (hit && !overlap_en) begin
      fill_d = '0;
    end else if (take && state_q == FILL) begin
      fill_d = fill_q + 1'b1;
    end
    state_d = (fill_d == FULL) ? ARMED : FILL;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      fill_q      <= '0;
      hist_q      <= '0;
      pat_q       <= PATTERN_INIT;
      match       <= 1'b0;
      armed       <= 1'b0;
      match_count <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      match   <= hit;
      armed   <= (state_d == ARMED);
      if (pattern_load) begin
        pat_q <= pattern_in;
      end
      if (count_clr) begin
        match_count <= '0;
      end else if (hit && match_count != '1) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: queue-based reference model plus
// directed vectors with hand-computed expectations.
module tb_seq_pattern_detector;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       value_valid = 1'b0;
  logic       value = 1'b0;
  logic       overlap_en = 1'b0;
  logic       pattern_load = 1'b0;
  logic [5:0] pattern_in = 6'd0;
  logic       count_clr = 1'b0;
  logic       match;
  logic       armed;
  logic [1:0] match_count;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  seq_pattern_detector #(
    .PATTERN_LEN (6),
    .PATTERN_INIT(6'b010111),
    .COUNT_W     (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .value_valid (value_valid),
    .value       (value),
    .overlap_en  (overlap_en),
    .pattern_load(pattern_load),
    .pattern_in  (pattern_in),
    .count_clr   (count_clr),
    .match       (match),
    .armed       (armed),
    .match_count (match_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // reference model: all accepted bits in a queue, fresh-bit count since
  // the last restart (load or non-overlapping match)
  logic       mq[$];
  int         mn = 0;
  logic [5:0] mpat = 6'b010111;
  logic       mmatch = 1'b0;
  int         mcnt = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mn = 0;
      mpat = 6'b010111;
      mmatch = 1'b0;
      mcnt = 0;
    end else begin
      logic       h;
      logic [5:0] w;
      h = 1'b0;
      w = 6'd0;
      if (pattern_load) begin
        mpat = pattern_in;
        mn = 0;
      end else if (value_valid) begin
        mq.push_back(value);
        if (mq.size() > 40) void'(mq.pop_front());
        if (mn + 1 >= 6) begin
          for (int i = 0; i < 6; i++) w[i] = mq[mq.size()-1-i];
          h = (w == mpat);
        end
        if (h && !overlap_en) mn = 0;
        else if (mn < 6) mn++;
      end
      mmatch = h;
      if (count_clr) mcnt = 0;
      else if (h && mcnt < 3) mcnt++;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("model_match", match, mmatch);
      chk("model_armed", armed, mn == 6);
      chk("model_count", match_count, mcnt);
    end
  end

  task automatic step(input logic v, input logic b,
                      input logic ld = 1'b0,
                      input logic [5:0] pi = 6'd0,
                      input logic clr = 1'b0);
    value_valid = v;
    value = b;
    pattern_load = ld;
    pattern_in = pi;
    count_clr = clr;
    @(negedge clock);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i]);
      pulses += int'(match);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_match", match, 0);
    chk("rst_armed", armed, 0);
    chk("rst_count", match_count, 0);
    reset = 1'b1;
    step(1'b0, 1'b0);

    // 1: default pattern, non-overlap
    overlap_en = 1'b0;
    pulses = 0;
    stream(6'b010111, 6);
    chk("t1_match", match, 1);
    chk("t1_count", match_count, 1);
    chk("t1_armed", armed, 0);
    step(1'b0, 1'b0);
    chk("t1_pulse_end", match, 0);
    chk("t1_armed_after", armed, 0);

    // 2: reload 101101, overlap then non-overlap
    step(1'b0, 1'b0, 1'b1, 6'b101101);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    overlap_en = 1'b1;
    pulses = 0;
    stream(9'b101101101, 9);
    chk("t2_ov_pulses", pulses, 2);
    chk("t2_ov_last", match, 1);
    chk("t2_ov_count", match_count, 2);
    overlap_en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 6'b101101);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    pulses = 0;
    stream(9'b101101101, 9);
    chk("t2_nov_pulses", pulses, 1);
    chk("t2_nov_count", match_count, 1);

    // 3: idle cycles inside the stream
    step(1'b0, 1'b0, 1'b1, 6'b010111);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    pulses = 0;
    stream(3'b010, 3);
    repeat (5) step(1'b0, 1'b1);
    stream(3'b111, 3);
    chk("t3_pulses", pulses, 1);
    chk("t3_last", match, 1);
    chk("t3_count", match_count, 1);

    // 4: saturation, then clear colliding with a match
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    pulses = 0;
    repeat (4) stream(6'b010111, 6);
    chk("t4_pulses", pulses, 4);
    chk("t4_sat", match_count, 3);
    stream(5'b01011, 5);
    step(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
    chk("t4_clr_match", match, 1);
    chk("t4_clr_count", match_count, 0);
    step(1'b0, 1'b0);

    // 5: load on the sixth bit discards it and restarts the fill
    stream(5'b01011, 5);
    step(1'b1, 1'b1, 1'b1, 6'b010111);
    chk("t5_no_match", match, 0);
    chk("t5_armed0", armed, 0);
    step(1'b0, 1'b0);
    stream(5'b11111, 5);
    chk("t5_refill5", armed, 0);
    stream(1'b1, 1);
    chk("t5_refill6", armed, 1);
    chk("t5_nomatch6", match, 0);

    // 6: reset while a match is pending
    stream(6'b010111, 6);
    chk("t6_pre_count", match_count, 1);
    step(1'b0, 1'b0, 1'b1, 6'b111000);
    stream(5'b11100, 5);
    value_valid = 1'b1;
    value = 1'b0;
    #2 reset = 1'b0;
    @(negedge clock);
    chk("t6_match", match, 0);
    chk("t6_count", match_count, 0);
    chk("t6_armed", armed, 0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    pulses = 0;
    stream(6'b010111, 6);
    chk("t6_init_pat", match, 1);
    chk("t6_init_pulses", pulses, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
